// File: rtl/mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mult_issue_ctrl
//
// Front-end for an iterative multiplier. It accepts one tagged RISC-V style
// multiply request (MUL / MULH / MULHSU / MULHU) at a time. It launches the
// multiplier with a single-cycle pulse and captures the 2*WIDTH product on the
// multiplier's res_ready pulse. It then returns the selected WIDTH-bit result
// with its tag. Requests with a zero operand bypass the multiplier.
// A flush drops the current request or result. If a multiply is already
// running, the block first absorbs the multiplier's completion pulse.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               discard accepted / pending / in-flight work
//   req_valid/req_ready request handshake
//   req_op              00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1, req_rs2    operands A / B
//   req_tag             tag echoed with the result
//   mul_valid           one-cycle launch pulse to the multiplier
//   mul_usigned         1 = unsigned multiply
//   mul_multiplicand    registered rs1
//   mul_multiplier      registered rs2
//   mul_product         2*WIDTH product from the multiplier
//   mul_res_ready       product-valid pulse from the multiplier
//   rsp_valid/rsp_ready response handshake
//   rsp_data, rsp_tag   result and its tag
// All outputs are registered.
// -----------------------------------------------------------------------------
module mult_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [WIDTH-1:0]     req_rs1,
    input  logic [WIDTH-1:0]     req_rs2,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 mul_valid,
    output logic                 mul_usigned,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_res_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [TAG_W-1:0]     rsp_tag
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_req_ready;
    logic                   r_mul_valid;
    logic                   r_rsp_valid;
    logic                   r_usigned;
    logic [1:0]             r_op;
    logic [WIDTH-1:0]       r_rs1;
    logic [WIDTH-1:0]       r_rs2;
    logic [TAG_W-1:0]       r_tag;
    logic [WIDTH-1:0]       r_rsp_data;

    logic                   w_req_ready_nxt;
    logic                   w_mul_valid_nxt;
    logic                   w_rsp_valid_nxt;
    logic                   w_accept;
    logic                   w_zero_op;
    logic                   w_capture;
    logic [WIDTH-1:0]       w_result;

    // Result select. The multiplier runs MULHSU as unsigned x unsigned. When
    // rs1 is negative, its signed value is rs1 - 2^W, so rs2 is subtracted
    // from the high half to correct for this.
    function automatic logic [WIDTH-1:0] select_result(
        input logic [1:0]         op,
        input logic [2*WIDTH-1:0] product,
        input logic [WIDTH-1:0]   rs1,
        input logic [WIDTH-1:0]   rs2
    );
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] corr;
        hi   = product[2*WIDTH-1:WIDTH];
        corr = rs1[WIDTH-1] ? rs2 : {WIDTH{1'b0}};
        case (op)
            OP_MUL:    select_result = product[WIDTH-1:0];
            OP_MULH:   select_result = hi;
            OP_MULHSU: select_result = hi - corr;
            OP_MULHU:  select_result = hi;
            default:   select_result = {WIDTH{1'b0}};
        endcase
    endfunction

    // A request is only taken when the registered ready is high. Flush wins.
    assign w_accept  = r_req_ready & req_valid & ~flush;
    assign w_zero_op = (req_rs1 == {WIDTH{1'b0}}) | (req_rs2 == {WIDTH{1'b0}});
    // A product is kept only if it arrives in WAIT and no flush occurs that cycle.
    assign w_capture = (r_state == S_WAIT) & mul_res_ready & ~flush;
    assign w_result  = select_result(r_op, mul_product, r_rs1, r_rs2);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero_op ? S_RESP : S_LAUNCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // The same-cycle pulse is the one being drained, so go straight to IDLE.
                    w_state_nxt = mul_res_ready ? S_IDLE : S_DRAIN;
                end else if (mul_res_ready) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_DRAIN: begin
                if (mul_res_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the next state. The results are registered below, so
    // each flag is high exactly while the FSM is in its owning state.
    always_comb begin
        w_req_ready_nxt = 1'b0;
        w_mul_valid_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        case (w_state_nxt)
            S_IDLE:   w_req_ready_nxt = 1'b1;
            S_LAUNCH: w_mul_valid_nxt = 1'b1;
            S_WAIT:   w_req_ready_nxt = 1'b0;
            S_RESP:   w_rsp_valid_nxt = 1'b1;
            S_DRAIN:  w_req_ready_nxt = 1'b0;
            default:  w_req_ready_nxt = 1'b0;
        endcase
    end

    // Registered handshake / launch flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_ready <= 1'b0;
            r_mul_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_mul_valid <= w_mul_valid_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Request capture and result register. The operand registers change only
    // on accept, so they stay stable for the whole multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= 2'b00;
            r_usigned  <= 1'b0;
            r_rs1      <= {WIDTH{1'b0}};
            r_rs2      <= {WIDTH{1'b0}};
            r_tag      <= {TAG_W{1'b0}};
            r_rsp_data <= {WIDTH{1'b0}};
        end else begin
            if (w_accept) begin
                r_op      <= req_op;
                // MUL takes the low half, which is sign-independent, so only
                // MULH needs a signed multiply.
                r_usigned <= (req_op != OP_MULH);
                r_rs1     <= req_rs1;
                r_rs2     <= req_rs2;
                r_tag     <= req_tag;
                if (w_zero_op) begin
                    r_rsp_data <= {WIDTH{1'b0}};
                end
            end else if (w_capture) begin
                r_rsp_data <= w_result;
            end
        end
    end

    assign req_ready        = r_req_ready;
    assign mul_valid        = r_mul_valid;
    assign mul_usigned      = r_usigned;
    assign mul_multiplicand = r_rs1;
    assign mul_multiplier   = r_rs2;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign rsp_tag          = r_tag;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for mult_issue_ctrl (WIDTH = 32, TAG_W = 4).
// A small multiplier model returns a product after a fixed latency. The model
// forms the product from the operands and the signedness the DUT presents.
// Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mult_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [3:0]  req_tag;
    logic        mul_valid;
    logic        mul_usigned;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [63:0] mul_product;
    logic        mul_res_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_issue_ctrl #(.WIDTH(32), .TAG_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_rs1          (req_rs1),
        .req_rs2          (req_rs2),
        .req_tag          (req_tag),
        .mul_valid        (mul_valid),
        .mul_usigned      (mul_usigned),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_res_ready    (mul_res_ready),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_tag          (rsp_tag)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle. On return, the bench is in the cycle after accept.
    task automatic send_req(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        cyc();
        req_valid = 1'b0;
    endtask

    // Multiplier model: lat cycles after the call, pulse res_ready with the product.
    task automatic pulse_product(input int lat);
        logic [63:0] ea;
        logic [63:0] eb;
        repeat (lat) cyc();
        if (mul_usigned) begin
            ea = {32'd0, mul_multiplicand};
            eb = {32'd0, mul_multiplier};
        end else begin
            ea = {{32{mul_multiplicand[31]}}, mul_multiplicand};
            eb = {{32{mul_multiplier[31]}}, mul_multiplier};
        end
        mul_product   = ea * eb;
        mul_res_ready = 1'b1;
        cyc();
        mul_res_ready = 1'b0;
        mul_product   = 64'd0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({req_ready, mul_valid, mul_usigned, rsp_valid} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {req_ready, mul_valid, mul_usigned, rsp_valid});
        checks++;
        if ({mul_multiplicand, mul_multiplier, rsp_data, rsp_tag} !== 100'd0)
            $display("FAIL reset_data: got %h expected 0", {mul_multiplicand, mul_multiplier, rsp_data, rsp_tag});
        if (({req_ready, mul_valid, mul_usigned, rsp_valid} !== 4'b0000) ||
            ({mul_multiplicand, mul_multiplier, rsp_data, rsp_tag} !== 100'd0)) errors++;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_mul();
        send_req(2'b00, 32'd7, 32'd6, 4'h5);
        checks++;
        if ({mul_valid, mul_usigned, req_ready} !== 3'b110) begin
            errors++;
            $display("FAIL mul_launch: got %b expected 110", {mul_valid, mul_usigned, req_ready});
        end
        cyc();
        checks++;
        if (mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_one_pulse: got %b expected 0", mul_valid);
        end
        pulse_product(2);
        checks++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'd42, 4'h5}) begin
            errors++;
            $display("FAIL mul_rsp: got %b %h %h expected 1 0000002a 5", rsp_valid, rsp_data, rsp_tag);
        end
        finish_rsp();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mul_handshake: got %b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_mulh_mulhu();
        logic [1:0]  ops[3] = '{2'b01, 2'b11, 2'b01};
        logic [31:0] as[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        logic        us[3]  = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp[3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            send_req(ops[i], as[i], bs[i], 4'(i + 8));
            checks++;
            if (mul_usigned !== us[i]) begin
                errors++;
                $display("FAIL mulh_usigned[%0d]: got %b expected %b", i, mul_usigned, us[i]);
            end
            pulse_product(3);
            checks++;
            if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, exp[i], 4'(i + 8)}) begin
                errors++;
                $display("FAIL mulh_rsp[%0d]: got %b %h %h expected 1 %h %h", i, rsp_valid, rsp_data, rsp_tag, exp[i], 4'(i + 8));
            end
            finish_rsp();
        end
    endtask

    task automatic test_mulhsu();
        logic [31:0] as[2]  = '{32'hFFFF_FFFF, 32'h0000_0003};
        logic [31:0] bs[2]  = '{32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp[2] = '{32'hFFFF_FFFF, 32'h0000_0001};
        for (int i = 0; i < 2; i++) begin
            send_req(2'b10, as[i], bs[i], 4'(i + 2));
            checks++;
            if (mul_usigned !== 1'b1) begin
                errors++;
                $display("FAIL mulhsu_usigned[%0d]: got %b expected 1", i, mul_usigned);
            end
            pulse_product(1);
            checks++;
            if ({rsp_valid, rsp_data} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL mulhsu_rsp[%0d]: got %b %h expected 1 %h", i, rsp_valid, rsp_data, exp[i]);
            end
            finish_rsp();
        end
    endtask

    task automatic test_bypass();
        send_req(2'b11, 32'd0, 32'h0000_1234, 4'h9);
        checks++;
        if ({rsp_valid, mul_valid, rsp_data, rsp_tag} !== {1'b1, 1'b0, 32'd0, 4'h9}) begin
            errors++;
            $display("FAIL bypass_rsp: got %b %b %h %h expected 1 0 00000000 9", rsp_valid, mul_valid, rsp_data, rsp_tag);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({rsp_valid, mul_valid, req_ready, rsp_data, rsp_tag} !== {3'b100, 32'd0, 4'h9}) begin
                errors++;
                $display("FAIL bypass_hold[%0d]: got %b%b%b %h %h expected 100 00000000 9", i, rsp_valid, mul_valid, req_ready, rsp_data, rsp_tag);
            end
        end
        finish_rsp();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bypass_handshake: got %b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_flush_idle();
        // Flush beats a simultaneous request; a stray product pulse in IDLE is ignored.
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd2;
        req_rs2   = 32'd2;
        req_tag   = 4'h1;
        flush     = 1'b1;
        cyc();
        req_valid = 1'b0;
        flush     = 1'b0;
        mul_product   = 64'd99;
        mul_res_ready = 1'b1;
        cyc();
        mul_res_ready = 1'b0;
        mul_product   = 64'd0;
        checks++;
        if ({mul_valid, rsp_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_idle: got %b expected 001", {mul_valid, rsp_valid, req_ready});
        end
    endtask

    task automatic test_flush_wait();
        send_req(2'b00, 32'd9, 32'd9, 4'h1);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if ({req_ready, rsp_valid, mul_valid} !== 3'b000) begin
            errors++;
            $display("FAIL flush_drain: got %b expected 000", {req_ready, rsp_valid, mul_valid});
        end
        pulse_product(2);
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_drain_exit: got %b expected 10", {req_ready, rsp_valid});
        end
        send_req(2'b00, 32'd3, 32'd5, 4'h6);
        pulse_product(2);
        checks++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'd15, 4'h6}) begin
            errors++;
            $display("FAIL flush_next_req: got %b %h %h expected 1 0000000f 6", rsp_valid, rsp_data, rsp_tag);
        end
        finish_rsp();
    endtask

    task automatic test_flush_same_cycle();
        send_req(2'b00, 32'd4, 32'd4, 4'h2);
        cyc();
        flush         = 1'b1;
        mul_product   = 64'd16;
        mul_res_ready = 1'b1;
        cyc();
        flush         = 1'b0;
        mul_res_ready = 1'b0;
        mul_product   = 64'd0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_same_cycle: got %b expected 01", {rsp_valid, req_ready});
        end
        cyc();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_same_cycle_after: got %b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_flush_resp();
        send_req(2'b00, 32'd0, 32'd8, 4'h7);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_resp: got %b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_reset_mid();
        send_req(2'b00, 32'd5, 32'd5, 4'h4);
        cyc();
        rst_n = 1'b0;
        cyc();
        checks++;
        if ({req_ready, mul_valid, mul_usigned, rsp_valid, mul_multiplicand, mul_multiplier, rsp_data, rsp_tag} !== 104'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {req_ready, mul_valid, mul_usigned, rsp_valid, mul_multiplicand, mul_multiplier, rsp_data, rsp_tag});
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b expected 1", req_ready);
        end
        send_req(2'b00, 32'd6, 32'd7, 4'h3);
        pulse_product(1);
        checks++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 32'd42, 4'h3}) begin
            errors++;
            $display("FAIL reset_mid_next: got %b %h %h expected 1 0000002a 3", rsp_valid, rsp_data, rsp_tag);
        end
        finish_rsp();
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        req_valid     = 1'b0;
        req_op        = 2'b00;
        req_rs1       = 32'd0;
        req_rs2       = 32'd0;
        req_tag       = 4'h0;
        mul_product   = 64'd0;
        mul_res_ready = 1'b0;
        rsp_ready     = 1'b0;
        test_reset();
        test_mul();
        test_mulh_mulhu();
        test_mulhsu();
        test_bypass();
        test_flush_idle();
        test_flush_wait();
        test_flush_same_cycle();
        test_flush_resp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Request/response front-end that sits directly upstream of the iterative multiplier unit and consumes its product. It accepts tagged multiply requests over a valid/ready handshake and decodes the RISC-V-style op (MUL, MULH, MULHSU, MULHU). It drives the multiplier's single-cycle `valid`/`usigned` launch, captures the 2·WIDTH product on the multiplier's `res_ready` pulse, and applies the MULHSU sign correction. It then returns a WIDTH-bit result with its tag over a second valid/ready handshake. It also provides a zero-operand bypass and a flush that discards in-flight work.

## Interface
- `WIDTH`, default 32: operand width; must equal the multiplier's `parallelism`.
- `TAG_W`, default 4: request tag width.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discards accepted, pending, and in-flight requests.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  2  00 = MUL, 01 = MULH, 10 = MULHSU, 11 = MULHU.
- `req_rs1`  in  WIDTH  operand A; goes to the multiplier's `multiplicand`.
- `req_rs2`  in  WIDTH  operand B; goes to the multiplier's `multiplier`.
- `req_tag`  in  TAG_W  returned unchanged with the result.
- `mul_valid`  out  1  launch pulse to the multiplier.
- `mul_usigned`  out  1  1 = unsigned multiply.
- `mul_multiplicand`  out  WIDTH  registered rs1.
- `mul_multiplier`  out  WIDTH  registered rs2.
- `mul_product`  in  2·WIDTH  product from the multiplier.
- `mul_res_ready`  in  1  one-cycle pulse; `mul_product` is valid in this cycle.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  WIDTH  result.
- `rsp_tag`  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register op, rs1, rs2, tag.
  - If rs1 == 0 or rs2 == 0: load `rsp_data` = 0 and go to RESP (bypass; the multiplier is not launched).
  - Otherwise go to LAUNCH.
- LAUNCH:
  - `mul_valid` = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On `mul_res_ready`, compute and register the result, then go to RESP.
  - Otherwise stay in WAIT.
- RESP:
  - `rsp_valid` = 1; `rsp_data` and `rsp_tag` are held stable.
  - On `rsp_ready`, go to IDLE.
- DRAIN:
  - Wait for `mul_res_ready`, discard the product, then go to IDLE.
- Operand registers drive `mul_multiplicand`/`mul_multiplier` and stay stable from LAUNCH until the product is captured. The multiplier samples them over several cycles after launch.
- `mul_usigned` (registered with the op):
  - MUL = 1 (the low half is sign-independent).
  - MULH = 0.
  - MULHSU = 1.
  - MULHU = 1.
- Result select, P = `mul_product`:
  - MUL: P[WIDTH-1:0].
  - MULH, MULHU: P[2W-1:W].
  - MULHSU: P[2W-1:W] − (rs1[W-1] ? rs2 : 0), modulo 2^WIDTH.
- Flush:
  - In IDLE or RESP: the current request/result is dropped; `rsp_valid` deasserts next cycle; go to IDLE.
  - In LAUNCH or WAIT: go to DRAIN. The multiplier cannot be aborted, so its pulse must be absorbed before a new launch.
  - If `mul_res_ready` and `flush` occur in the same WAIT cycle: the result is discarded and the FSM goes to IDLE.
  - In DRAIN: no effect.
  - Flush has priority over `req_valid` in IDLE; no request is accepted that cycle.
- Outputs held at 0 outside their owning state: `mul_valid` outside LAUNCH, `rsp_valid` outside RESP.
- A `mul_res_ready` pulse arriving in IDLE, LAUNCH, or RESP is a protocol error. It is ignored.

## Timing
- Reset state: IDLE. All outputs are 0: `req_ready`, `mul_valid`, `mul_usigned`, `mul_multiplicand`, `mul_multiplier`, `rsp_valid`, `rsp_data`, `rsp_tag`.
- `req_ready` is driven high only from the IDLE state and is low during reset.
- Bypass path: request accepted in cycle 0 → `rsp_valid` high in cycle 1.
- Normal path:
  - Accept in cycle 0 → `mul_valid` high in cycle 1.
  - `mul_res_ready` high in cycle N → `rsp_valid` high in cycle N+1.
- Throughput: one request in flight. The next accept is possible in the cycle after the `rsp_valid`·`rsp_ready` handshake.
- Reset mid-operation: the FSM returns to IDLE. The multiplier shares `rst_n`, so no drain is needed.
- All outputs are registered; there is no combinational path from `req_*` or `rsp_ready` to any output.

## Test plan
- MUL: rs1 = 7, rs2 = 6 → `mul_usigned` = 1, one `mul_valid` pulse; `rsp_data` = 42, tag echoed.
- MULH and MULHU with 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH → `mul_usigned` = 0, `rsp_data` = 0x00000000.
  - MULHU → `rsp_data` = 0xFFFFFFFE.
  - MULH 0x80000000 × 2 → `rsp_data` = 0xFFFFFFFF.
- MULHSU: rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF → `rsp_data` = 0xFFFFFFFF. rs1 = 3, rs2 = 0x80000000 → `rsp_data` = 0x00000001.
- Bypass: MULHU rs1 = 0, rs2 = 0x1234 → `mul_valid` never asserts, `rsp_valid` in the cycle after accept, `rsp_data` = 0. Hold `rsp_ready` = 0 for 5 cycles → data/tag stable, `req_ready` = 0.
- Flush in WAIT:
  - Expected: FSM enters DRAIN; the following `mul_res_ready` pulse produces no `rsp_valid`; `req_ready` returns 1 the cycle after the pulse; a new MUL 3 × 5 then returns 15.
  - Same-cycle flush + `mul_res_ready`: no response, IDLE next cycle.
- Reset mid-WAIT: assert `rst_n` = 0 for one cycle → all outputs 0, `req_ready` = 1 after release, next request completes correctly.
